// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_pkg
//  Description : Shared command codes, frame width, FSM states and frame
//                builder for the SPI RAM master.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_ram_pkg;

    localparam int FRAME_BITS = 10;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FRAME = 3'd1,
        RWAIT = 3'd2,
        RECV  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Read-data frames carry a zero payload; the slave answers on MISO.
    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic       we,
        input logic       data_phase,
        input logic [7:0] addr,
        input logic [7:0] wdata
    );
        logic [1:0] cmd;
        logic [7:0] payload;
        if (we) cmd = data_phase ? CMD_WR_DATA : CMD_WR_ADDR;
        else    cmd = data_phase ? CMD_RD_DATA : CMD_RD_ADDR;
        payload = data_phase ? (we ? wdata : 8'h00) : addr;
        return {cmd, payload};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ram_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_master_if
//  Description : Request/response handshake plus serial pins of the SPI RAM
//                master; "master" is the sequencer side, "slave" the far side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_ram_master_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [7:0]           req_wdata;
    logic                 rsp_valid;
    logic                 rsp_we;
    logic [7:0]           rsp_rdata;
    logic                 busy;
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, MISO,
        output req_ready, rsp_valid, rsp_we, rsp_rdata, busy, SS_n, MOSI
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, MISO,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata, busy, SS_n, MOSI
    );
endinterface
`default_nettype wire

// File: rtl/spi_frame_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_shifter
//  Description : Emits control bit + 10-bit frame MSB first on MOSI and
//                gathers 8 MISO bits, flagging the last bit of each.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_shifter
    import spi_ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [FRAME_BITS-1:0] i_din,
    input  logic                  i_tx_en,
    input  logic                  i_rx_en,
    input  logic                  i_miso,
    output logic                  o_mosi,
    output logic                  o_tx_last,
    output logic                  o_rx_last,
    output logic [7:0]            o_rx_data
);

    localparam logic [3:0] c_tx_last = 4'(FRAME_BITS);

    logic [FRAME_BITS:0] r_tx_sr;
    logic [3:0]          r_tx_cnt;
    logic [7:0]          r_rx_sr;
    logic [2:0]          r_rx_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sr  <= '0;
            r_tx_cnt <= '0;
            r_rx_sr  <= '0;
            r_rx_cnt <= '0;
        end else if (i_load) begin
            // Control bit duplicates din[9] ahead of the frame itself.
            r_tx_sr  <= {i_din[FRAME_BITS-1], i_din};
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (i_tx_en) begin
                r_tx_sr  <= {r_tx_sr[FRAME_BITS-1:0], 1'b0};
                r_tx_cnt <= r_tx_cnt + 4'd1;
            end
            if (i_rx_en) begin
                r_rx_sr  <= {r_rx_sr[6:0], i_miso};
                r_rx_cnt <= r_rx_cnt + 3'd1;
            end
        end
    end

    assign o_mosi    = r_tx_sr[FRAME_BITS];
    assign o_tx_last = (r_tx_cnt == c_tx_last);
    assign o_rx_last = (r_rx_cnt == 3'd7);
    assign o_rx_data = r_rx_sr;

endmodule
`default_nettype wire

// File: rtl/spi_ram_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_master
//  Description : Turns single-word read/write requests into address + data
//                SPI frames. Define SPI_RAM_MASTER_ADDR_CACHE_EN to skip the
//                address frame when it repeats the last one of the same op.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_WAIT    = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    spi_ram_master_if.master bus
);

    localparam logic [7:0] c_rwait_last = 8'(RD_WAIT - 1);
    localparam logic [7:0] c_gap_last   = 8'(GAP_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_cnt;
    logic                  r_we;
    logic [7:0]            r_addr;
    logic [7:0]            r_wdata;
    logic                  r_data_phase;
    logic                  r_rsp_we;
    logic [7:0]            r_rdata;
    logic                  w_load;
    logic [FRAME_BITS-1:0] w_din;
    logic                  w_tx_en;
    logic                  w_rx_en;
    logic                  w_mosi_bit;
    logic                  w_tx_last;
    logic                  w_rx_last;
    logic [7:0]            w_rx_data;
    logic                  w_hit;
    logic [7:0]            w_req_addr;

    assign w_req_addr = bus.req_addr[7:0];

    spi_frame_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_din     (w_din),
        .i_tx_en   (w_tx_en),
        .i_rx_en   (w_rx_en),
        .i_miso    (bus.MISO),
        .o_mosi    (w_mosi_bit),
        .o_tx_last (w_tx_last),
        .o_rx_last (w_rx_last),
        .o_rx_data (w_rx_data)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_din        = frame_word(r_we, 1'b1, r_addr, r_wdata);
        w_tx_en      = 1'b0;
        w_rx_en      = 1'b0;
        case (r_state)
            IDLE: if (bus.req_valid) begin
                w_state_next = FRAME;
                w_load       = 1'b1;
                w_din        = frame_word(bus.req_we, w_hit, w_req_addr, bus.req_wdata);
            end
            FRAME: begin
                w_tx_en = 1'b1;
                if (w_tx_last) begin
                    if (!r_we && r_data_phase) w_state_next = (RD_WAIT == 0) ? RECV : RWAIT;
                    else                       w_state_next = GAP;
                end
            end
            RWAIT: if (r_cnt == c_rwait_last) w_state_next = RECV;
            RECV: begin
                w_rx_en = 1'b1;
                if (w_rx_last) w_state_next = GAP;
            end
            GAP: if (r_cnt == c_gap_last) begin
                if (!r_data_phase) begin
                    w_state_next = FRAME;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_data_phase <= 1'b0;
            r_rsp_we     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_state_next;
            // Wait counter restarts on every state change.
            r_cnt   <= (w_state_next != r_state) ? 8'd0 : r_cnt + 8'd1;
            if (r_state == IDLE && bus.req_valid) begin
                r_we         <= bus.req_we;
                r_addr       <= w_req_addr;
                r_wdata      <= bus.req_wdata;
                r_data_phase <= w_hit;
            end
            if (r_state == GAP && w_state_next == FRAME) r_data_phase <= 1'b1;
            if (r_state == GAP && w_state_next == DONE) begin
                r_rsp_we <= r_we;
                if (!r_we) r_rdata <= w_rx_data;
            end
        end
    end

`ifdef SPI_RAM_MASTER_ADDR_CACHE_EN
    logic [7:0] r_last_waddr;
    logic [7:0] r_last_raddr;
    logic       r_waddr_vld;
    logic       r_raddr_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_waddr <= '0;
            r_last_raddr <= '0;
            r_waddr_vld  <= 1'b0;
            r_raddr_vld  <= 1'b0;
        end else if (r_state == FRAME && w_tx_last && !r_data_phase) begin
            if (r_we) begin
                r_last_waddr <= r_addr;
                r_waddr_vld  <= 1'b1;
            end else begin
                r_last_raddr <= r_addr;
                r_raddr_vld  <= 1'b1;
            end
        end
    end

    assign w_hit = bus.req_we ? (r_waddr_vld && r_last_waddr == w_req_addr)
                              : (r_raddr_vld && r_last_raddr == w_req_addr);
`else
    assign w_hit = 1'b0;
`endif

    generate
        if (ADDR_SIZE > 8) begin : g_addr_chk
            a_addr_range : assert property (@(posedge clk) disable iff (rst)
                (bus.req_valid && bus.req_ready) |-> (bus.req_addr[ADDR_SIZE-1:8] == '0));
        end
    endgenerate

    assign bus.req_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.SS_n      = !(r_state == FRAME || r_state == RWAIT || r_state == RECV);
    assign bus.MOSI      = (r_state == FRAME) && w_mosi_bit;
    assign bus.rsp_valid = (r_state == DONE);
    assign bus.rsp_we    = r_rsp_we;
    assign bus.rsp_rdata = r_rdata;

endmodule
`default_nettype wire
